sc_stream_counter: RTL and testbench
====================================

SC_STREAM_COUNTER -- requirements
Module: sc_stream_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: binary result width; window length W = 2^WIDTH-1 samples (255 at default, one full 8-bit LFSR period).
REQ-002 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-high (asserted = 1).
REQ-004 SHALL have port start, input, 1: request a new conversion window.
REQ-005 SHALL have port in_bit, input, 1: stochastic bitstream from the upstream comparator/OR stage.
REQ-006 SHALL have port in_valid, input, 1: in_bit is a valid sample this cycle.
REQ-007 SHALL have port busy, output, 1: high while a window is being accumulated.
REQ-008 SHALL have port result, output, WIDTH: number of ones counted in the last completed window.
REQ-009 SHALL have port result_valid, output, 1: result is available.
REQ-010 SHALL have port result_ready, input, 1: consumer accepts result.

Function
REQ-011 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-012 SHALL move IDLE->ACCUM on start=1, clearing the ones counter and the sample counter in the same edge.
REQ-013 SHALL, in ACCUM, increment the sample counter only on cycles with in_valid=1, and the ones counter only on in_valid=1 and in_bit=1.
REQ-014 SHALL ignore in_bit when in_valid=0, and in IDLE and DONE.
REQ-015 SHALL move ACCUM->DONE on the edge that consumes sample W, registering result = final ones count, including that sample.
REQ-016 SHALL assert result_valid=1 from the first cycle in DONE, with result stable until the handshake completes.
REQ-017 SHALL complete the handshake on a cycle with result_valid=1 and result_ready=1, then go DONE->IDLE.
REQ-018 SHALL, when start=1 coincides with the handshake cycle, go directly DONE->ACCUM with cleared counters (back-to-back windows).
REQ-019 SHALL ignore start in ACCUM, and in DONE without handshake.
REQ-020 SHALL drive busy=1 exactly in ACCUM.
REQ-021 SHALL keep result at its last value in IDLE and ACCUM; it is meaningful only while result_valid=1.
REQ-022 SHALL, with all in_valid=1, have latency from start to result_valid = W+1 cycles.
REQ-023 SHALL never overflow the ones counter: maximum count W = 2^WIDTH-1 fits in WIDTH bits.

Reset
REQ-024 SHALL, on rst_n=1 at any time (including mid-ACCUM), immediately force state=IDLE, busy=0, result_valid=0, result=0, both counters=0.
REQ-025 SHALL discard any partial window on reset; after release, a new start is required.

Configuration
REQ-026 SHALL use macro SC_BIPOLAR_RESULT_EN.
REQ-027 SHALL, with SC_BIPOLAR_RESULT_EN defined, add output result_bp, signed WIDTH+1 bits, = 2*count - W, registered with result and reset to 0.
REQ-028 SHALL, without SC_BIPOLAR_RESULT_EN, omit result_bp; unipolar behaviour is unchanged.

Structure
REQ-029 SHALL take the state enum, the default WIDTH, and the W-derivation function from shared package sc_pkg.
REQ-030 SHALL instantiate one sub-module, sc_window_counter: enable-gated sample counter with terminal-count flag at W; the ones counter stays in the top level.

Verification
REQ-031 SHALL cover: start, 255 valid samples all 1 -> result=255, result_valid at cycle 256 after start; with macro, result_bp=+255.
REQ-032 SHALL cover: start, 255 valid samples alternating 1/0 starting with 1 -> result=128; with macro, result_bp=+1.
REQ-033 SHALL cover: start, in_valid toggling 1/0 each cycle, in_bit=1 -> busy for 510 cycles, result=255; in_bit on invalid cycles is ignored.
REQ-034 SHALL cover: rst_n pulsed at sample 100 of a window -> busy=0 and result_valid=0 immediately, result=0; next window of all zeros -> result=0.
REQ-035 SHALL cover: result_ready held 0 for 20 cycles in DONE -> result stable and start ignored; then result_ready=1 with start=1 -> busy=1 next cycle.
REQ-036 SHALL cover: start asserted during ACCUM -> no restart; sample counter unaffected.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic stream counter.
// Window length is one full LFSR period: W = 2^WIDTH - 1 samples.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } sc_state_t;

    localparam int SC_WIDTH_DEFAULT = 8;

    function automatic int sc_window_len(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Enable-gated sample counter; tc flags the cycle that consumes sample W.
// The counter wraps to zero on that cycle, so it is ready for the next window.
module sc_window_counter
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(sc_window_len(WIDTH) - 1);

    logic [WIDTH-1:0] count;

    assign tc = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_stream_counter.sv
// Counts ones in a W-sample window of a stochastic bitstream and hands the
// count out over a valid/ready handshake. Optional SC_BIPOLAR_RESULT_EN adds result_bp.
//   state | meaning
//   IDLE  | waiting for start
//   ACCUM | counting valid samples, busy=1
//   DONE  | result_valid=1, waiting for result_ready
module sc_stream_counter
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,   // active-high despite the name
    input  logic             start,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
`ifdef SC_BIPOLAR_RESULT_EN
    ,
    output logic signed [WIDTH:0] result_bp
`endif
);

    localparam int W = sc_window_len(WIDTH);

    sc_state_t        state;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] ones_next;
    logic             handshake;
    logic             launch;
    logic             win_en;
    logic             win_tc;

    assign handshake = (state == DONE) && result_ready;
    assign launch    = start && ((state == IDLE) || handshake);
    assign win_en    = (state == ACCUM) && in_valid;
    assign ones_next = ones + WIDTH'(in_bit);

    sc_window_counter #(.WIDTH(WIDTH)) u_window (
        .clk   (clk),
        .rst   (rst_n),
        .clear (launch),
        .en    (win_en),
        .tc    (win_tc)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            ones         <= '0;
`ifdef SC_BIPOLAR_RESULT_EN
            result_bp    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                        ones  <= '0;
                    end
                end
                ACCUM: begin
                    if (win_en) begin
                        ones <= ones_next;
                        if (win_tc) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            result       <= ones_next;
`ifdef SC_BIPOLAR_RESULT_EN
                            // 2*count - W always fits in WIDTH+1 signed bits
                            result_bp    <= $signed({ones_next, 1'b0} - (WIDTH+1)'(W));
`endif
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            state <= ACCUM;
                            busy  <= 1'b1;
                            ones  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_stream_counter.sv
// Scoreboard bench for sc_stream_counter: stimulus pushes expected window counts,
// a negedge monitor pops and compares on every result handshake.
module tb_sc_stream_counter;

    localparam int WIDTH = 8;
    localparam int W     = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             in_bit;
    logic             in_valid;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
`ifdef SC_BIPOLAR_RESULT_EN
    logic signed [WIDTH:0] result_bp;
`endif

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int last_exp = 0;
    int mon_e;

    always #5 clk = ~clk;

    sc_stream_counter #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_bit       (in_bit),
        .in_valid     (in_valid),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
`ifdef SC_BIPOLAR_RESULT_EN
        ,
        .result_bp    (result_bp)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one pop per completed handshake.
    always @(negedge clk) begin
        if (result_valid === 1'b1 && result_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_result", int'(result), mon_e);
`ifdef SC_BIPOLAR_RESULT_EN
                check("sb_result_bp", int'(result_bp), 2 * mon_e - W);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_window();
        start    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        step();
        start    = 1'b0;
        check("start_busy", int'(busy), 1);
    endtask

    // bit_mode: 0 all ones, 1 alternating from 1, 2 random, 3 all zeros
    // val_mode: 0 always valid, 1 toggling from 0, 2 random (~75%)
    task automatic accumulate(input int bit_mode, input int val_mode, input bit noise,
                              input int nsamples, input string tag, output int busy_cnt);
        int nvalid = 0;
        int ones = 0;
        int cyc = 0;
        int rv_early = 0;
        bit v;
        bit b;
        busy_cnt = 0;
        while (nvalid < nsamples && cyc < 8 * W) begin
            case (val_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            case (bit_mode)
                0:       b = 1'b1;
                1:       b = (nvalid % 2 == 0);
                2:       b = 1'($urandom_range(0, 1));
                default: b = 1'b0;
            endcase
            in_valid = v;
            in_bit   = v ? b : ((bit_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (result_valid === 1'b1) rv_early++;
            if (v) begin
                nvalid++;
                ones += int'(b);
            end
            cyc++;
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (nvalid < nsamples) check({tag, "_timeout"}, nvalid, nsamples);
        check({tag, "_busy_cycles"}, busy_cnt, cyc);
        check({tag, "_rv_early"}, rv_early, 0);
        if (nsamples == W) begin
            exp_q.push_back(ones);
            last_exp = ones;
            check({tag, "_rv_done"}, int'(result_valid), 1);
            check({tag, "_busy_done"}, int'(busy), 0);
        end
    endtask

    task automatic finish(input int hold, input bit next_start, input int exp);
        for (int k = 0; k < hold; k++) begin
            result_ready = 1'b0;
            start        = (k % 2 == 0);
            step();
            check("hold_result", int'(result), exp);
            check("hold_rv", int'(result_valid), 1);
            check("hold_busy", int'(busy), 0);
        end
        start        = next_start;
        result_ready = 1'b1;
        step();
        start        = 1'b0;
        result_ready = 1'b0;
        check("hs_rv", int'(result_valid), 0);
        check("hs_busy", int'(busy), int'(next_start));
    endtask

    initial begin
        int bc;
        rst_n        = 1'b1;
        start        = 1'b0;
        in_bit       = 1'b0;
        in_valid     = 1'b0;
        result_ready = 1'b0;
        repeat (3) step();
        check("rst_busy", int'(busy), 0);
        check("rst_rv", int'(result_valid), 0);
        check("rst_result", int'(result), 0);
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (5) step();
        in_valid = 1'b0;
        check("idle_busy", int'(busy), 0);
        check("idle_rv", int'(result_valid), 0);

        begin_window();
        accumulate(0, 0, 1'b0, W, "all1", bc);
        check("all1_latency", bc + 1, 256);
        check("all1_result", int'(result), 255);
`ifdef SC_BIPOLAR_RESULT_EN
        check("all1_bp", int'(result_bp), 255);
`endif
        finish(0, 1'b0, 255);

        begin_window();
        accumulate(1, 0, 1'b0, W, "alt", bc);
        check("alt_result", int'(result), 128);
`ifdef SC_BIPOLAR_RESULT_EN
        check("alt_bp", int'(result_bp), 1);
`endif
        finish(20, 1'b1, 128);

        accumulate(0, 1, 1'b0, W, "toggle", bc);
        check("toggle_busy_510", bc, 510);
        check("toggle_result", int'(result), 255);
        finish(0, 1'b0, 255);

        for (int n = 0; n < 4; n++) begin
            begin_window();
            accumulate(2, 2, 1'b1, W, "rand", bc);
            finish($urandom_range(0, 3), 1'b0, last_exp);
        end

        begin_window();
        accumulate(2, 0, 1'b0, 100, "partial", bc);
        rst_n = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_rv", int'(result_valid), 0);
        check("midrst_result", int'(result), 0);
`ifdef SC_BIPOLAR_RESULT_EN
        check("midrst_bp", int'(result_bp), 0);
`endif
        step();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        check("postrst_busy", int'(busy), 0);
        check("postrst_rv", int'(result_valid), 0);

        begin_window();
        accumulate(3, 0, 1'b0, W, "zeros", bc);
        check("zeros_result", int'(result), 0);
        finish(0, 1'b0, 0);

        repeat (2) step();
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
